// File: rtl/femto_bus_fabric_pkg.sv
// Shared definitions for the FemtoRV32 bus fabric.
//   bus_state_t       : transaction FSM states
//   DEFAULT_ERR_RDATA : read data returned for error / timeout responses
//   DEC_HI / DEC_LO   : mem_addr bit range compared against slave base prefixes
//   sel_width()       : width of a slave index for a given slave count
package femto_bus_fabric_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_WR_WAIT = 2'd2,
        ST_ERR     = 2'd3
    } bus_state_t;

    localparam logic [31:0] DEFAULT_ERR_RDATA = 32'hDEADBEEF;
    localparam int          DEC_HI            = 31;
    localparam int          DEC_LO            = 16;

    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/femto_bus_fabric_if.sv
// CPU-side memory bus of the FemtoRV32 core.
//   mem_addr  : byte address from the CPU
//   mem_rstrb : one-cycle read strobe
//   mem_wmask : byte write mask, nonzero acts as a one-cycle write strobe
//   mem_rdata : read data back to the CPU
//   mem_rbusy : read in progress, CPU stalls
//   mem_wbusy : write in progress, CPU stalls
// Modports: master = CPU, slave = fabric.
interface femto_bus_fabric_if;

    logic [31:0] mem_addr;
    logic        mem_rstrb;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata;
    logic        mem_rbusy;
    logic        mem_wbusy;

    modport master (
        output mem_addr, mem_rstrb, mem_wmask,
        input  mem_rdata, mem_rbusy, mem_wbusy
    );

    modport slave (
        input  mem_addr, mem_rstrb, mem_wmask,
        output mem_rdata, mem_rbusy, mem_wbusy
    );

endinterface

// File: rtl/femto_bus_fabric_timeout.sv
// Busy-cycle counter used to abort transactions whose slave never finishes.
//   clk, reset : clock, asynchronous active-high reset
//   clear      : restart the count at zero (wins over enable)
//   enable     : count one more busy cycle
//   expired    : count has reached TIMEOUT_CYCLES-1
// TIMEOUT_CYCLES = 0 disables the counter entirely; expired is then constant 0.
module femto_bus_fabric_timeout #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_off
            logic unused_inputs;
            assign unused_inputs = &{1'b0, clk, reset, clear, enable};
            assign expired       = 1'b0;
        end else begin : g_on
            localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

            logic [CNT_W-1:0] count_reg;
            logic [CNT_W-1:0] count_next;

            assign expired = (count_reg == CNT_W'(TIMEOUT_CYCLES - 1));

            // Holding at the terminal value keeps the counter from wrapping
            // if the caller keeps enable high after expiry.
            always_comb begin
                count_next = count_reg;
                if (clear) begin
                    count_next = '0;
                end else if (enable && !expired) begin
                    count_next = count_reg + 1'b1;
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    count_reg <= '0;
                end else begin
                    count_reg <= count_next;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/femto_bus_fabric.sv
// CPU-to-peripheral interconnect for the FemtoRV32 SoC.
// Decodes mem_addr[31:16] against per-slave base prefixes, issues per-slave
// read/write strobes, muxes read data and busy from the selected slave, and
// adds busy timeout plus unmapped-address error responses with sticky capture.
//   clk, reset  : clock, asynchronous active-high reset
//   cpu         : CPU bus (fabric side of femto_bus_fabric_if)
//   s_cs        : one-hot chip select decoded from the current mem_addr
//   s_rd, s_wr  : per-slave strobes, only issued from IDLE
//   s_rdata     : packed slave read data, slot i = bits [32i+31:32i]
//   s_rbusy     : per-slave read busy
//   s_wbusy     : per-slave write busy
//   err_clear   : one-cycle clear of err_valid
//   err_valid   : sticky flag, an error or timeout occurred
//   err_addr    : address of the first error since the last clear
//   err_timeout : first error was a timeout (0: unmapped access)
module femto_bus_fabric
    import femto_bus_fabric_pkg::*;
#(
    parameter int                     NUM_SLAVES       = 7,
    parameter logic [16*NUM_SLAVES-1:0] SLAVE_BASE     = '0,
    parameter int                     DEFAULT_SLAVE    = 0,
    parameter int                     UNMAPPED_DEFAULT = 1,
    parameter int                     TIMEOUT_CYCLES   = 1024,
    parameter logic [31:0]            ERR_RDATA        = DEFAULT_ERR_RDATA
) (
    input  logic                     clk,
    input  logic                     reset,
    femto_bus_fabric_if.slave        cpu,
    output logic [NUM_SLAVES-1:0]    s_cs,
    output logic [NUM_SLAVES-1:0]    s_rd,
    output logic [NUM_SLAVES-1:0]    s_wr,
    input  logic [32*NUM_SLAVES-1:0] s_rdata,
    input  logic [NUM_SLAVES-1:0]    s_rbusy,
    input  logic [NUM_SLAVES-1:0]    s_wbusy,
    input  logic                     err_clear,
    output logic                     err_valid,
    output logic [31:0]              err_addr,
    output logic                     err_timeout
);

    localparam int SEL_W = sel_width(NUM_SLAVES);

    bus_state_t        state_reg, state_next;
    logic [SEL_W-1:0]  sel_reg, sel_next;
    logic [31:0]       addr_reg, addr_next;

    logic [NUM_SLAVES-1:0] base_match;
    logic [31:0]           rdata_slot [NUM_SLAVES];
    logic                  dec_hit;
    logic                  dec_mapped;
    logic [SEL_W-1:0]      dec_idx;

    logic        wr_req;
    logic        rd_req;
    logic        in_idle;
    logic        rbusy_sel;
    logic        wbusy_sel;
    logic [31:0] rdata_sel;

    logic        tmo_clear;
    logic        tmo_enable;
    logic        tmo_expired;

    logic        err_entry;
    logic        err_is_timeout;
    logic [31:0] err_addr_cap;

    logic        err_valid_reg;
    logic [31:0] err_addr_reg;
    logic        err_timeout_reg;

    // ------------------------------------------------------------------
    // Address decode and per-slot unpacking
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLAVES; gi++) begin : g_slot
            assign base_match[gi] = (SLAVE_BASE[16*gi +: 16] == cpu.mem_addr[DEC_HI:DEC_LO]);
            assign rdata_slot[gi] = s_rdata[32*gi +: 32];
            assign s_cs[gi]       = dec_mapped && (dec_idx == SEL_W'(gi));
        end
    endgenerate

    // Scanning downwards lets the lowest matching index overwrite any
    // higher one, so duplicate prefixes resolve to the lowest slot.
    always_comb begin
        dec_hit = 1'b0;
        dec_idx = SEL_W'(DEFAULT_SLAVE);
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (base_match[i]) begin
                dec_hit = 1'b1;
                dec_idx = SEL_W'(i);
            end
        end
    end

    assign dec_mapped = dec_hit || (UNMAPPED_DEFAULT != 0);

    // ------------------------------------------------------------------
    // Strobes: a write in the same cycle as a read suppresses the read.
    // ------------------------------------------------------------------
    assign wr_req  = |cpu.mem_wmask;
    assign rd_req  = cpu.mem_rstrb && !wr_req;
    assign in_idle = (state_reg == ST_IDLE);

    assign s_rd = (in_idle && rd_req) ? s_cs : '0;
    assign s_wr = (in_idle && wr_req) ? s_cs : '0;

    assign rbusy_sel = s_rbusy[sel_reg];
    assign wbusy_sel = s_wbusy[sel_reg];
    assign rdata_sel = rdata_slot[sel_reg];

    // ------------------------------------------------------------------
    // Busy timeout
    // ------------------------------------------------------------------
    femto_bus_fabric_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (tmo_clear),
        .enable  (tmo_enable),
        .expired (tmo_expired)
    );

    // ------------------------------------------------------------------
    // Transaction FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        sel_next       = sel_reg;
        addr_next      = addr_reg;
        tmo_clear      = 1'b0;
        tmo_enable     = 1'b0;
        err_entry      = 1'b0;
        err_is_timeout = 1'b0;
        err_addr_cap   = addr_reg;
        cpu.mem_rbusy  = 1'b0;
        cpu.mem_wbusy  = 1'b0;
        cpu.mem_rdata  = rdata_sel;

        case (state_reg)
            ST_IDLE: begin
                if (wr_req || cpu.mem_rstrb) begin
                    addr_next = cpu.mem_addr;
                    tmo_clear = 1'b1;
                    if (!dec_mapped) begin
                        // Unmapped access: no slave sees a strobe and
                        // sel_reg keeps pointing at the last real target.
                        state_next   = ST_ERR;
                        err_entry    = 1'b1;
                        err_addr_cap = cpu.mem_addr;
                    end else begin
                        sel_next   = dec_idx;
                        state_next = wr_req ? ST_WR_WAIT : ST_RD_WAIT;
                    end
                end
            end

            ST_RD_WAIT: begin
                cpu.mem_rbusy = rbusy_sel;
                if (!rbusy_sel) begin
                    state_next = ST_IDLE;
                end else if (tmo_expired) begin
                    state_next     = ST_ERR;
                    err_entry      = 1'b1;
                    err_is_timeout = 1'b1;
                end else begin
                    tmo_enable = 1'b1;
                end
            end

            ST_WR_WAIT: begin
                cpu.mem_wbusy = wbusy_sel;
                if (!wbusy_sel) begin
                    state_next = ST_IDLE;
                end else if (tmo_expired) begin
                    state_next     = ST_ERR;
                    err_entry      = 1'b1;
                    err_is_timeout = 1'b1;
                end else begin
                    tmo_enable = 1'b1;
                end
            end

            ST_ERR: begin
                cpu.mem_rdata = ERR_RDATA;
                state_next    = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            sel_reg   <= SEL_W'(DEFAULT_SLAVE);
            addr_reg  <= '0;
        end else begin
            state_reg <= state_next;
            sel_reg   <= sel_next;
            addr_reg  <= addr_next;
        end
    end

    // ------------------------------------------------------------------
    // Sticky error capture. A new error in the same cycle as err_clear
    // takes precedence and reloads the captured fields.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_valid_reg   <= 1'b0;
            err_addr_reg    <= '0;
            err_timeout_reg <= 1'b0;
        end else begin
            if (err_entry) begin
                err_valid_reg <= 1'b1;
                if (!err_valid_reg || err_clear) begin
                    err_addr_reg    <= err_addr_cap;
                    err_timeout_reg <= err_is_timeout;
                end
            end else if (err_clear) begin
                err_valid_reg <= 1'b0;
            end
        end
    end

    assign err_valid   = err_valid_reg;
    assign err_addr    = err_addr_reg;
    assign err_timeout = err_timeout_reg;

endmodule

// File: tb/tb_femto_bus_fabric.sv
module tb_femto_bus_fabric;

    localparam int N   = 7;
    localparam int TMO = 8;
    // slot: 0=0000 flash, 1=0001 dpram, 2=0020, 3=0030, 4=0010, 5=0040 uart, 6=0040 (duplicate)
    localparam logic [16*N-1:0] BASES = {16'h0040, 16'h0040, 16'h0010, 16'h0030,
                                         16'h0020, 16'h0001, 16'h0000};

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    femto_bus_fabric_if bus_a ();
    femto_bus_fabric_if bus_b ();

    logic [N-1:0]   a_cs, a_rd, a_wr, b_cs, b_rd, b_wr;
    logic [32*N-1:0] s_rdata;
    logic [N-1:0]   s_rbusy, s_wbusy;
    logic           a_clr, b_clr;
    logic           a_ev, a_eto, b_ev, b_eto;
    logic [31:0]    a_ea, b_ea;

    femto_bus_fabric #(
        .NUM_SLAVES(N), .SLAVE_BASE(BASES), .DEFAULT_SLAVE(0),
        .UNMAPPED_DEFAULT(1), .TIMEOUT_CYCLES(TMO), .ERR_RDATA(32'hDEADBEEF)
    ) dut_a (
        .clk(clk), .reset(reset), .cpu(bus_a),
        .s_cs(a_cs), .s_rd(a_rd), .s_wr(a_wr),
        .s_rdata(s_rdata), .s_rbusy(s_rbusy), .s_wbusy(s_wbusy),
        .err_clear(a_clr), .err_valid(a_ev), .err_addr(a_ea), .err_timeout(a_eto)
    );

    femto_bus_fabric #(
        .NUM_SLAVES(N), .SLAVE_BASE(BASES), .DEFAULT_SLAVE(0),
        .UNMAPPED_DEFAULT(0), .TIMEOUT_CYCLES(TMO), .ERR_RDATA(32'hDEADBEEF)
    ) dut_b (
        .clk(clk), .reset(reset), .cpu(bus_b),
        .s_cs(b_cs), .s_rd(b_rd), .s_wr(b_wr),
        .s_rdata(s_rdata), .s_rbusy(s_rbusy), .s_wbusy(s_wbusy),
        .err_clear(b_clr), .err_valid(b_ev), .err_addr(b_ea), .err_timeout(b_eto)
    );

    // Behavioural slaves: a strobe loads the busy length, then it counts down.
    int rleft [N];
    int wleft [N];
    int lat_cur = 0;

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (a_rd[i] || b_rd[i])  rleft[i] <= lat_cur;
            else if (rleft[i] > 0)   rleft[i] <= rleft[i] - 1;
            if (a_wr[i] || b_wr[i])  wleft[i] <= lat_cur;
            else if (wleft[i] > 0)   wleft[i] <= wleft[i] - 1;
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            s_rbusy[i] = (rleft[i] != 0);
            s_wbusy[i] = (wleft[i] != 0);
        end
    end

    // Reference model state
    logic [15:0] base_m [N] = '{16'h0000, 16'h0001, 16'h0020, 16'h0030, 16'h0010, 16'h0040, 16'h0040};
    logic [31:0] rd_m [N];
    bit          ev_m [2];
    logic [31:0] ea_m [2];
    bit          eto_m [2];

    int n_tests = 0;
    int n_fail  = 0;

    logic [N-1:0] o_cs, o_rd, o_wr;
    logic [31:0]  o_rdata, o_ea;
    logic         o_rbusy, o_wbusy, o_ev, o_eto;

    function automatic int model_target(input int inst, input logic [31:0] addr);
        for (int i = 0; i < N; i++) begin
            if (base_m[i] == addr[31:16]) return i;
        end
        return (inst == 0) ? 0 : -1;
    endfunction

    task automatic set_cpu(input int inst, input logic [31:0] addr, input logic rd,
                           input logic [3:0] wm, input logic clr);
        if (inst == 0) begin
            bus_a.mem_addr = addr; bus_a.mem_rstrb = rd; bus_a.mem_wmask = wm; a_clr = clr;
        end else begin
            bus_b.mem_addr = addr; bus_b.mem_rstrb = rd; bus_b.mem_wmask = wm; b_clr = clr;
        end
    endtask

    task automatic sample(input int inst);
        if (inst == 0) begin
            o_cs = a_cs; o_rd = a_rd; o_wr = a_wr; o_rdata = bus_a.mem_rdata;
            o_rbusy = bus_a.mem_rbusy; o_wbusy = bus_a.mem_wbusy;
            o_ev = a_ev; o_ea = a_ea; o_eto = a_eto;
        end else begin
            o_cs = b_cs; o_rd = b_rd; o_wr = b_wr; o_rdata = bus_b.mem_rdata;
            o_rbusy = bus_b.mem_rbusy; o_wbusy = bus_b.mem_wbusy;
            o_ev = b_ev; o_ea = b_ea; o_eto = b_eto;
        end
    endtask

    // One complete transaction, checked against the model.
    task automatic run_txn(input int inst, input logic [31:0] addr, input logic rd,
                           input logic [3:0] wm, input int lat, input logic clr,
                           input string name);
        int           tgt, nb;
        bit           is_wr, is_err, is_to, done;
        int           exp_busy;
        logic [31:0]  exp_rdata;
        logic [N-1:0] exp_cs, exp_rd, exp_wr;

        tgt    = model_target(inst, addr);
        is_wr  = (wm != 4'h0);
        is_err = (tgt < 0);
        is_to  = !is_err && (lat >= TMO);
        exp_cs = '0;
        if (tgt >= 0) exp_cs[tgt] = 1'b1;
        exp_rd = (!is_wr && rd) ? exp_cs : '0;
        exp_wr = is_wr ? exp_cs : '0;
        exp_busy = is_err ? 0 : (is_to ? TMO : lat);
        for (int i = 0; i < N; i++) rd_m[i] = $urandom;
        exp_rdata = (is_err || is_to) ? 32'hDEADBEEF : rd_m[tgt];

        // sticky error model: a new error always wins over a clear
        if (is_err || is_to) begin
            if (!ev_m[inst] || clr) begin
                ea_m[inst]  = addr;
                eto_m[inst] = is_to;
            end
            ev_m[inst] = 1'b1;
        end else if (clr) begin
            ev_m[inst] = 1'b0;
        end

        @(posedge clk); #1;
        lat_cur = lat;
        for (int i = 0; i < N; i++) s_rdata[32*i +: 32] = rd_m[i];
        set_cpu(inst, addr, rd, wm, clr);
        @(negedge clk);
        sample(inst);
        n_tests++;
        if (o_cs !== exp_cs) begin
            n_fail++; $display("FAIL %s s_cs got=%b exp=%b", name, o_cs, exp_cs);
        end
        n_tests++;
        if (o_rd !== exp_rd) begin
            n_fail++; $display("FAIL %s s_rd got=%b exp=%b", name, o_rd, exp_rd);
        end
        n_tests++;
        if (o_wr !== exp_wr) begin
            n_fail++; $display("FAIL %s s_wr got=%b exp=%b", name, o_wr, exp_wr);
        end
        @(posedge clk); #1;
        set_cpu(inst, addr, 1'b0, 4'h0, 1'b0);

        nb = 0; done = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            sample(inst);
            if (!(is_wr ? o_wbusy : o_rbusy)) begin
                done = 1'b1;
                break;
            end
            nb++;
        end
        n_tests++;
        if (!done) begin
            n_fail++; $display("FAIL %s busy_timeout got=stuck exp=done", name);
        end
        n_tests++;
        if (nb != exp_busy) begin
            n_fail++; $display("FAIL %s busy_cycles got=%0d exp=%0d", name, nb, exp_busy);
        end
        n_tests++;
        if (o_rdata !== exp_rdata) begin
            n_fail++; $display("FAIL %s rdata got=%h exp=%h", name, o_rdata, exp_rdata);
        end
        n_tests++;
        if (o_ev !== ev_m[inst]) begin
            n_fail++; $display("FAIL %s err_valid got=%b exp=%b", name, o_ev, ev_m[inst]);
        end
        if (ev_m[inst]) begin
            n_tests++;
            if (o_ea !== ea_m[inst]) begin
                n_fail++; $display("FAIL %s err_addr got=%h exp=%h", name, o_ea, ea_m[inst]);
            end
            n_tests++;
            if (o_eto !== eto_m[inst]) begin
                n_fail++; $display("FAIL %s err_timeout got=%b exp=%b", name, o_eto, eto_m[inst]);
            end
        end
        $display("[TB] %s inst=%0d addr=%h rd=%0d wm=%h lat=%0d busy=%0d rdata=%h err=%0d",
                 name, inst, addr, rd, wm, lat, nb, o_rdata, o_ev);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_cpu(0, 32'h0, 1'b0, 4'h0, 1'b0);
        set_cpu(1, 32'h0, 1'b0, 4'h0, 1'b0);
        for (int i = 0; i < N; i++) s_rdata[32*i +: 32] = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int inst = 0; inst < 2; inst++) begin
            sample(inst);
            n_tests++;
            if (o_rbusy !== 1'b0 || o_wbusy !== 1'b0) begin
                n_fail++; $display("FAIL reset_busy inst=%0d got=%b%b exp=00", inst, o_rbusy, o_wbusy);
            end
            n_tests++;
            if (o_rd !== '0 || o_wr !== '0) begin
                n_fail++; $display("FAIL reset_strobe inst=%0d got=%b/%b exp=0", inst, o_rd, o_wr);
            end
            n_tests++;
            if (o_ev !== 1'b0 || o_eto !== 1'b0 || o_ea !== 32'h0) begin
                n_fail++; $display("FAIL reset_err inst=%0d got=%b %b %h exp=0 0 0", inst, o_ev, o_eto, o_ea);
            end
            n_tests++;
            if (o_cs !== 7'b0000001) begin
                n_fail++; $display("FAIL reset_cs inst=%0d got=%b exp=0000001", inst, o_cs);
            end
        end
        $display("[TB] reset checked");
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_default_map();
        run_txn(0, 32'h0040_0004, 1'b1, 4'h0, 0, 1'b0, "uart_read");
        run_txn(0, 32'h0001_0010, 1'b1, 4'h0, 5, 1'b0, "dpram_read");
        run_txn(0, 32'h0050_0008, 1'b1, 4'h0, 2, 1'b0, "unmapped_default");
        run_txn(0, 32'h0030_0000, 1'b0, 4'h3, 3, 1'b0, "write_wait");
    endtask

    task automatic test_timeout();
        run_txn(0, 32'h0000_0100, 1'b1, 4'h0, 20, 1'b0, "flash_timeout");
        // slave is still busy here; the fabric must not pass that on
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            sample(0);
            n_tests++;
            if (o_rbusy !== 1'b0) begin
                n_fail++; $display("FAIL late_busy_ignored cycle=%0d got=%b exp=0", k, o_rbusy);
            end
        end
        run_txn(0, 32'h0010_0000, 1'b0, 4'hF, 7, 1'b0, "write_near_timeout");
    endtask

    task automatic test_unmapped_error();
        run_txn(1, 32'h0099_0000, 1'b0, 4'hF, 0, 1'b0, "unmapped_write");
        run_txn(1, 32'h0098_0000, 1'b1, 4'h0, 0, 1'b0, "second_error");
        run_txn(1, 32'h0050_0004, 1'b1, 4'h0, 0, 1'b1, "clear_with_error");
        run_txn(1, 32'h0020_0000, 1'b1, 4'h0, 1, 1'b1, "clear_on_txn");
    endtask

    task automatic test_write_wins();
        run_txn(0, 32'h0040_0000, 1'b1, 4'hF, 2, 1'b0, "write_wins");
        run_txn(1, 32'h0040_000C, 1'b1, 4'h1, 0, 1'b0, "write_wins_b");
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        lat_cur = 10;
        set_cpu(0, 32'h0001_0020, 1'b1, 4'h0, 1'b0);
        @(posedge clk); #1;
        set_cpu(0, 32'h0001_0020, 1'b0, 4'h0, 1'b0);
        @(negedge clk);
        sample(0);
        n_tests++;
        if (o_rbusy !== 1'b1) begin
            n_fail++; $display("FAIL reset_mid_busy got=%b exp=1", o_rbusy);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            ev_m[i] = 1'b0; ea_m[i] = 32'h0; eto_m[i] = 1'b0;
        end
        @(negedge clk);
        sample(0);
        n_tests++;
        if (o_rbusy !== 1'b0 || o_ev !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid_abort got=%b/%b exp=0/0", o_rbusy, o_ev);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        sample(0);
        n_tests++;
        if (o_rbusy !== 1'b0 || o_ev !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid_idle got=%b/%b exp=0/0", o_rbusy, o_ev);
        end
        $display("[TB] reset_mid checked busy=%b err=%b", o_rbusy, o_ev);
        run_txn(0, 32'h0040_0010, 1'b1, 4'h0, 1, 1'b0, "after_reset");
    endtask

    task automatic test_random();
        logic [15:0] pfx [8] = '{16'h0000, 16'h0001, 16'h0020, 16'h0030,
                                 16'h0010, 16'h0040, 16'h0050, 16'h0099};
        logic [31:0] addr;
        logic [3:0]  wm;
        logic        rd, clr;
        int          inst, lat;
        for (int t = 0; t < 40; t++) begin
            inst = int'($urandom_range(0, 1));
            addr = {pfx[$urandom_range(0, 7)], 16'($urandom)};
            wm   = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
            rd   = (wm == 4'h0) ? 1'b1 : 1'($urandom_range(0, 1));
            lat  = int'($urandom_range(0, 10));
            clr  = ($urandom_range(0, 7) == 0);
            run_txn(inst, addr, rd, wm, lat, clr, "random");
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            ev_m[i] = 1'b0; ea_m[i] = 32'h0; eto_m[i] = 1'b0;
        end
        test_reset();
        test_default_map();
        test_timeout();
        test_unmapped_error();
        test_write_wins();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
